// File: rtl/core_ctrl.sv
// Multi-cycle fetch/decode/execute/writeback sequencer for the single-issue integer core.
// Undecodable instructions park the core in TRAP until reset.
module core_ctrl #(
   parameter int               XLEN     = 32,
   parameter logic [XLEN-1:0]  RESET_PC = 32'h0000_0000
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            run,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_ready,
   input  logic [31:0]     imem_rdata,
   output logic [31:0]     ir,
   input  logic [4:0]      dec_rs1,
   input  logic [4:0]      dec_rs2,
   input  logic [4:0]      dec_rd,
   input  logic            dec_is_add,
   input  logic            dec_is_sub,
   output logic [4:0]      rf_ra1,
   output logic [4:0]      rf_ra2,
   input  logic [XLEN-1:0] rf_rd1,
   input  logic [XLEN-1:0] rf_rd2,
   output logic [XLEN-1:0] alu_a,
   output logic [XLEN-1:0] alu_b,
   output logic            alu_sub,
   input  logic [XLEN-1:0] alu_y,
   output logic            rf_we,
   output logic [4:0]      rf_wa,
   output logic [XLEN-1:0] rf_wd,
   output logic [XLEN-1:0] pc,
   output logic            retire,
   output logic [31:0]     instret,
   output logic            illegal
);

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_FETCH  = 3'd1;
   localparam logic [2:0] ST_DECODE = 3'd2;
   localparam logic [2:0] ST_EXEC   = 3'd3;
   localparam logic [2:0] ST_WB     = 3'd4;
   localparam logic [2:0] ST_TRAP   = 3'd5;

   logic [2:0]      state_r;
   logic [2:0]      state_nxt_s;
   logic [XLEN-1:0] pc_r;
   logic [31:0]     ir_r;
   logic [XLEN-1:0] a_r;
   logic [XLEN-1:0] b_r;
   logic [XLEN-1:0] res_r;
   logic [4:0]      rd_r;
   logic            sub_r;
   logic [31:0]     instret_r;
   logic            illegal_r;
   logic            legal_s;

   assign legal_s = dec_is_add | dec_is_sub;

   // Next-state selection; an unknown state encoding is treated as a trap.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (run) state_nxt_s = ST_FETCH;
            else     state_nxt_s = ST_IDLE;
         end
         ST_FETCH: begin
            if (imem_ready) state_nxt_s = ST_DECODE;
            else            state_nxt_s = ST_FETCH;
         end
         ST_DECODE: begin
            if (legal_s) state_nxt_s = ST_EXEC;
            else         state_nxt_s = ST_TRAP;
         end
         ST_EXEC: state_nxt_s = ST_WB;
         ST_WB: begin
            if (run) state_nxt_s = ST_FETCH;
            else     state_nxt_s = ST_IDLE;
         end
         ST_TRAP: state_nxt_s = ST_TRAP;
         default: state_nxt_s = ST_TRAP;
      endcase
   end

   // State, architectural registers and datapath latches.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r   <= ST_IDLE;
         pc_r      <= RESET_PC;
         ir_r      <= 32'h0000_0000;
         a_r       <= '0;
         b_r       <= '0;
         res_r     <= '0;
         rd_r      <= 5'd0;
         sub_r     <= 1'b0;
         instret_r <= 32'd0;
         illegal_r <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         case (state_r)
            ST_FETCH: begin
               if (imem_ready) ir_r <= imem_rdata;
            end
            ST_DECODE: begin
               a_r   <= rf_rd1;
               b_r   <= rf_rd2;
               rd_r  <= dec_rd;
               sub_r <= dec_is_sub;
               if (!legal_s) illegal_r <= 1'b1;
            end
            ST_EXEC: res_r <= alu_y;
            ST_WB: begin
               pc_r      <= pc_r + XLEN'(32'd4);
               instret_r <= instret_r + 32'd1;
            end
            ST_IDLE, ST_TRAP: ;
            default: illegal_r <= 1'b1;
         endcase
      end
   end

   // Strobes and steering decoded from state; everything is zero outside its own state.
   always_comb begin
      imem_req  = 1'b0;
      imem_addr = '0;
      rf_ra1    = 5'd0;
      rf_ra2    = 5'd0;
      alu_a     = '0;
      alu_b     = '0;
      alu_sub   = 1'b0;
      rf_we     = 1'b0;
      rf_wa     = 5'd0;
      rf_wd     = '0;
      retire    = 1'b0;
      case (state_r)
         ST_FETCH: begin
            imem_req  = 1'b1;
            imem_addr = pc_r;
         end
         ST_DECODE: begin
            rf_ra1 = dec_rs1;
            rf_ra2 = dec_rs2;
         end
         ST_EXEC: begin
            alu_a   = a_r;
            alu_b   = b_r;
            alu_sub = sub_r;
         end
         ST_WB: begin
            rf_we  = (rd_r != 5'd0);
            rf_wa  = rd_r;
            rf_wd  = res_r;
            retire = 1'b1;
         end
         default: ;
      endcase
   end

   assign pc      = pc_r;
   assign ir      = ir_r;
   assign instret = instret_r;
   assign illegal = illegal_r;

endmodule

// File: tb/tb_core_ctrl.sv
// Self-checking bench for core_ctrl: reference register model feeds a scoreboard of
// expected writebacks that is drained on every retire pulse.
module tb_core_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        run;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;
   logic [31:0] ir;
   logic [4:0]  dec_rs1, dec_rs2, dec_rd;
   logic        dec_is_add, dec_is_sub;
   logic [4:0]  rf_ra1, rf_ra2;
   logic [31:0] rf_rd1, rf_rd2;
   logic [31:0] alu_a, alu_b, alu_y;
   logic        alu_sub;
   logic        rf_we;
   logic [4:0]  rf_wa;
   logic [31:0] rf_wd;
   logic [31:0] pc;
   logic        retire;
   logic [31:0] instret;
   logic        illegal;

   // second instance with a wrapping reset PC
   logic        w_run;
   logic        w_req;
   logic [31:0] w_addr;
   logic [31:0] w_ir;
   logic [4:0]  w_ra1, w_ra2;
   logic [31:0] w_alu_a, w_alu_b, w_alu_y;
   logic        w_alu_sub;
   logic        w_we;
   logic [4:0]  w_wa;
   logic [31:0] w_wd;
   logic [31:0] w_pc;
   logic        w_retire;
   logic [31:0] w_instret;
   logic        w_illegal;

   logic [31:0] rf  [0:31];
   logic [31:0] ref_rf [0:31];
   logic [31:0] mem [0:15];

   typedef struct {
      logic [4:0]  wa;
      logic [31:0] wd;
      logic        we;
      logic [31:0] pc;
      logic        sub;
      int          start;
      int          lat;
   } sb_t;

   sb_t sb_q[$];
   int  waits_q[$];

   int  n_checks = 0;
   int  n_errors = 0;
   int  cyc_cnt = 0;
   int  hs_cnt = 0;
   int  start_cyc = 0;
   int  wait_left = 0;
   int  waits_used = 0;
   logic        prev_req = 1'b0;
   logic        prev_retire = 1'b0;
   logic        prev_alu_sub = 1'b0;
   logic        force_ready = 1'b0;
   logic [31:0] held_addr = 32'd0;
   logic [31:0] held_ir = 32'd0;

   always #5 clk = ~clk;

   function automatic logic is_add_f(input logic [31:0] w);
      return (w[6:0] == 7'h33) && (w[14:12] == 3'd0) && (w[31:25] == 7'h00);
   endfunction

   function automatic logic is_sub_f(input logic [31:0] w);
      return (w[6:0] == 7'h33) && (w[14:12] == 3'd0) && (w[31:25] == 7'h20);
   endfunction

   assign dec_rs1    = ir[19:15];
   assign dec_rs2    = ir[24:20];
   assign dec_rd     = ir[11:7];
   assign dec_is_add = is_add_f(ir);
   assign dec_is_sub = is_sub_f(ir);
   assign rf_rd1     = rf[rf_ra1];
   assign rf_rd2     = rf[rf_ra2];
   assign alu_y      = alu_sub ? (alu_a - alu_b) : (alu_a + alu_b);
   assign w_alu_y    = w_alu_sub ? (w_alu_a - w_alu_b) : (w_alu_a + w_alu_b);

   core_ctrl dut (
      .clk(clk), .rst_n(rst_n), .run(run),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
      .ir(ir), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd),
      .dec_is_add(dec_is_add), .dec_is_sub(dec_is_sub),
      .rf_ra1(rf_ra1), .rf_ra2(rf_ra2), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
      .alu_a(alu_a), .alu_b(alu_b), .alu_sub(alu_sub), .alu_y(alu_y),
      .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd),
      .pc(pc), .retire(retire), .instret(instret), .illegal(illegal)
   );

   core_ctrl #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC)) dut_w (
      .clk(clk), .rst_n(rst_n), .run(w_run),
      .imem_req(w_req), .imem_addr(w_addr), .imem_ready(w_req), .imem_rdata(32'h0020_81B3),
      .ir(w_ir), .dec_rs1(w_ir[19:15]), .dec_rs2(w_ir[24:20]), .dec_rd(w_ir[11:7]),
      .dec_is_add(is_add_f(w_ir)), .dec_is_sub(is_sub_f(w_ir)),
      .rf_ra1(w_ra1), .rf_ra2(w_ra2), .rf_rd1(rf[w_ra1]), .rf_rd2(rf[w_ra2]),
      .alu_a(w_alu_a), .alu_b(w_alu_b), .alu_sub(w_alu_sub), .alu_y(w_alu_y),
      .rf_we(w_we), .rf_wa(w_wa), .rf_wd(w_wd),
      .pc(w_pc), .retire(w_retire), .instret(w_instret), .illegal(w_illegal)
   );

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   // One clock: drain scoreboard on retire, model the memory handshake, push expectations.
   task automatic cyc();
      logic run_at_edge;
      sb_t  e;
      logic [31:0] w;
      run_at_edge = run;
      @(negedge clk);
      cyc_cnt++;
      if (retire) begin
         if (sb_q.size() == 0) begin
            check_val("sb_underflow", 32'd1, 32'd0);
         end else begin
            e = sb_q.pop_front();
            check_val("rf_wa", {27'd0, rf_wa}, {27'd0, e.wa});
            check_val("rf_wd", rf_wd, e.wd);
            check_val("rf_we", {31'd0, rf_we}, {31'd0, e.we});
            check_val("wb_pc", pc, e.pc);
            check_val("exec_alu_sub", {31'd0, prev_alu_sub}, {31'd0, e.sub});
            check_val("latency", cyc_cnt - e.start + 1, e.lat);
         end
         if (rf_we) rf[rf_wa] = rf_wd;
      end
      if (prev_retire && run_at_edge) check_val("b2b_req", {31'd0, imem_req}, 32'd1);
      if (imem_req && !prev_req) begin
         start_cyc  = cyc_cnt;
         waits_used = (waits_q.size() > 0) ? waits_q.pop_front() : 0;
         wait_left  = waits_used;
         held_addr  = imem_addr;
         held_ir    = ir;
      end
      if (imem_req) begin
         check_val("addr_eq_pc", imem_addr, pc);
         check_val("addr_stable", imem_addr, held_addr);
         check_val("ir_hold", ir, held_ir);
      end
      if (imem_req && wait_left == 0) begin
         w = mem[imem_addr[5:2]];
         imem_ready = 1'b1;
         imem_rdata = w;
         hs_cnt++;
         if (is_add_f(w) || is_sub_f(w)) begin
            e.wa    = w[11:7];
            e.sub   = is_sub_f(w);
            e.wd    = e.sub ? (ref_rf[w[19:15]] - ref_rf[w[24:20]])
                            : (ref_rf[w[19:15]] + ref_rf[w[24:20]]);
            e.we    = (w[11:7] != 5'd0);
            e.pc    = imem_addr;
            e.start = start_cyc;
            e.lat   = 4 + waits_used;
            if (e.we) ref_rf[e.wa] = e.wd;
            sb_q.push_back(e);
         end
      end else begin
         imem_ready = force_ready;
         imem_rdata = 32'hDEAD_BEEF;
         if (imem_req) wait_left--;
      end
      prev_req     = imem_req;
      prev_retire  = retire;
      prev_alu_sub = alu_sub;
   endtask

   task automatic clear_bench();
      sb_q.delete();
      waits_q.delete();
      wait_left   = 0;
      prev_req    = 1'b0;
      prev_retire = 1'b0;
      imem_ready  = 1'b0;
      hs_cnt      = 0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      run   = 1'b0;
      clear_bench();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic wait_hs(input int target);
      for (int i = 0; i < 100 && hs_cnt < target; i++) cyc();
      if (hs_cnt < target) check_val("hs_timeout", 32'd0, 32'd1);
   endtask

   initial begin
      logic seen1;
      rst_n = 1'b1; run = 1'b0; w_run = 1'b0;
      imem_ready = 1'b0; imem_rdata = 32'd0;
      for (int i = 0; i < 32; i++) begin rf[i] = 32'd0; ref_rf[i] = 32'd0; end
      rf[1] = 32'd5; rf[2] = 32'd7; rf[6] = 32'd3; rf[7] = 32'd10;
      ref_rf[1] = 32'd5; ref_rf[2] = 32'd7; ref_rf[6] = 32'd3; ref_rf[7] = 32'd10;
      for (int i = 0; i < 16; i++) mem[i] = 32'h0000_0013;

      // reset state
      do_reset();
      check_val("rst_pc", pc, 32'd0);
      check_val("rst_ir", ir, 32'd0);
      check_val("rst_instret", instret, 32'd0);
      check_val("rst_illegal", {31'd0, illegal}, 32'd0);
      check_val("rst_req", {31'd0, imem_req}, 32'd0);
      check_val("rst_retire", {31'd0, retire}, 32'd0);
      check_val("rst_we", {31'd0, rf_we}, 32'd0);
      check_val("rst_w_pc", w_pc, 32'hFFFF_FFFC);

      // add, sub (3 wait cycles), then illegal word at pc=8
      mem[0] = 32'h0020_81B3; mem[1] = 32'h4073_02B3; mem[2] = 32'h0000_0013;
      waits_q.push_back(0); waits_q.push_back(3); waits_q.push_back(0);
      cyc();
      run = 1'b1;
      cyc();
      check_val("req_after_run", {31'd0, imem_req}, 32'd1);
      seen1 = 1'b0;
      for (int i = 0; i < 100 && !illegal; i++) begin
         cyc();
         if (instret == 32'd1 && !seen1) begin
            seen1 = 1'b1;
            check_val("pc_after_add", pc, 32'd4);
         end
      end
      check_val("first_retire_seen", {31'd0, seen1}, 32'd1);
      check_val("trap_illegal", {31'd0, illegal}, 32'd1);
      check_val("trap_pc", pc, 32'd8);
      check_val("trap_ir", ir, 32'h0000_0013);
      check_val("trap_instret", instret, 32'd2);
      check_val("x3", rf[3], 32'd12);
      check_val("x5", rf[5], 32'hFFFF_FFF9);
      for (int i = 0; i < 5; i++) begin
         cyc();
         check_val("trap_no_req", {31'd0, imem_req}, 32'd0);
         check_val("trap_no_we", {31'd0, rf_we}, 32'd0);
         check_val("trap_no_retire", {31'd0, retire}, 32'd0);
      end
      check_val("sb_drained1", sb_q.size(), 32'd0);
      rst_n = 1'b0;
      #1;
      check_val("rstpulse_illegal", {31'd0, illegal}, 32'd0);
      check_val("rstpulse_pc", pc, 32'd0);
      do_reset();

      // write to x0, then add x3 with 2 waits and run dropped in EXEC
      mem[0] = 32'h0020_8033; mem[1] = 32'h0020_81B3;
      waits_q.push_back(0); waits_q.push_back(2);
      run = 1'b1;
      wait_hs(2);
      cyc();
      cyc();
      run = 1'b0;
      cyc();
      check_val("drop_retire", {31'd0, retire}, 32'd1);
      force_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         cyc();
         check_val("idle_req", {31'd0, imem_req}, 32'd0);
         check_val("idle_pc", pc, 32'd8);
         check_val("idle_ir", ir, 32'h0020_81B3);
      end
      force_ready = 1'b0;
      check_val("x0_instret", instret, 32'd2);
      check_val("sb_drained2", sb_q.size(), 32'd0);

      // reset asserted mid-fetch
      do_reset();
      waits_q.push_back(6);
      run = 1'b1;
      cyc();
      cyc();
      check_val("fetch_req", {31'd0, imem_req}, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check_val("async_req", {31'd0, imem_req}, 32'd0);
      check_val("async_instret", instret, 32'd0);
      check_val("async_we", {31'd0, rf_we}, 32'd0);
      do_reset();

      // wrap of pc from 0xFFFF_FFFC
      @(negedge clk);
      w_run = 1'b1;
      begin
         int k;
         k = 0;
         while (!w_retire && k < 20) begin @(negedge clk); k++; end
         check_val("w_retire_seen", {31'd0, w_retire}, 32'd1);
      end
      w_run = 1'b0;
      @(negedge clk);
      check_val("w_pc_wrap", w_pc, 32'd0);
      check_val("w_instret", w_instret, 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/core_ctrl.md
# core_ctrl

Multi-cycle sequencer for the single-issue integer core. It fetches each instruction over a request/ready handshake and latches it into an instruction register that feeds the instruction decoder. It then steers the register-file read ports from the decoded `rs1`/`rs2`, sequences the shared add/sub ALU, and writes the result back to `rd`. Undecodable instructions trap and halt the core.

## Interface
- `XLEN`, 32: datapath and PC width.
- `RESET_PC`, 32'h0000_0000: PC value loaded on reset.

- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `run`  in  1  level; allows the block to start or continue fetching.
- `imem_req`  out  1  fetch request, held until `imem_ready`.
- `imem_addr`  out  XLEN  fetch address, equal to `pc` while `imem_req` is high.
- `imem_ready`  in  1  fetch completes this cycle; `imem_rdata` is valid in the same cycle.
- `imem_rdata`  in  32  instruction word.
- `ir`  out  32  latched instruction, drives the decoder.
- `dec_rs1`, `dec_rs2`, `dec_rd`  in  5 each  decoder fields of `ir`.
- `dec_is_add`, `dec_is_sub`  in  1 each  decoder class flags; at most one is high.
- `rf_ra1`, `rf_ra2`  out  5 each  register-file read addresses; the register file reads combinationally.
- `rf_rd1`, `rf_rd2`  in  XLEN each  read data.
- `alu_a`, `alu_b`  out  XLEN each  ALU operands.
- `alu_sub`  out  1  1 selects subtract, 0 selects add.
- `alu_y`  in  XLEN  combinational ALU result.
- `rf_we`  out  1  write enable.
- `rf_wa`  out  5  write address.
- `rf_wd`  out  XLEN  write data.
- `pc`  out  XLEN  current program counter.
- `retire`  out  1  one-cycle pulse per completed instruction.
- `instret`  out  32  retired-instruction counter.
- `illegal`  out  1  sticky trap flag.

## Operation
- States: IDLE, FETCH, DECODE, EXEC, WB, TRAP.
- IDLE
  - All strobes are low.
  - `run`=1 moves to FETCH.
- FETCH
  - `imem_req`=1 and `imem_addr`=`pc`.
  - On `imem_ready`=1: `ir` <= `imem_rdata`, then go to DECODE.
  - `run` is ignored in this state; a started fetch always completes.
- DECODE
  - `rf_ra1`=`dec_rs1` and `rf_ra2`=`dec_rs2`.
  - Latch operand registers A <= `rf_rd1`, B <= `rf_rd2`. Latch rd_q <= `dec_rd` and sub_q <= `dec_is_sub`.
  - If `dec_is_add` or `dec_is_sub` is high, go to EXEC. Otherwise go to TRAP.
- EXEC
  - `alu_a`=A, `alu_b`=B, `alu_sub`=sub_q.
  - Latch res <= `alu_y`, then go to WB.
- WB
  - `rf_wa`=rd_q, `rf_wd`=res, `rf_we`=(rd_q != 0).
  - `pc` <= `pc`+4, truncated to XLEN; wraps 0xFFFF_FFFC -> 0.
  - `retire`=1 and `instret` <= `instret`+1; the counter wraps at 2^32.
  - Next state is FETCH if `run`=1, else IDLE.
- TRAP
  - `illegal`=1. `pc` is not advanced, so it still points at the offending instruction.
  - No further requests or writes are issued.
  - Only `rst_n` exits this state.
- Writes to x0 still retire and still advance `pc`; only `rf_we` is suppressed.
- `rf_ra1`/`rf_ra2` are 0 outside DECODE. `alu_*` are 0 outside EXEC. `rf_*` write outputs are 0 outside WB.

## Timing
- Reset values:
  - state=IDLE, `pc`=RESET_PC, `ir`=0, A=B=res=0, `instret`=0.
  - `illegal`=0, `retire`=0, `rf_we`=0, `imem_req`=0.
- Reset is asynchronous. Asserting `rst_n` mid-instruction drops `imem_req`/`rf_we` immediately, with no write and no retire.
- Minimum instruction latency is 4 cycles when `imem_ready` is high in the first FETCH cycle: FETCH, DECODE, EXEC, WB. Each wait cycle on `imem_ready` adds one cycle.
- Back-to-back throughput with `run`=1 is one instruction per 4 cycles. `imem_req` rises in the cycle after WB.
- `imem_ready` while `imem_req`=0 is ignored.
- `pc`, `instret`, `ir` and `illegal` are registered outputs. `imem_req`, `imem_addr`, `rf_*`, `alu_*` and `retire` are decoded from state and registers, with no input-to-output combinational paths except `rf_ra*` <- `dec_rs*`.

## Test plan
- Reset, `run`=1, memory returns `add x3,x1,x2` (0x002081B3) with x1=5, x2=7 and immediate ready:
  - `imem_req` rises 1 cycle after `run`.
  - WB in cycle 4 writes `rf_wa`=3, `rf_wd`=12.
  - `pc`=4, `instret`=1.
- `sub x5,x6,x7` (0x407302B3) with x6=3, x7=10 -> `alu_sub`=1 in EXEC, `rf_wd`=0xFFFF_FFF9, `rf_wa`=5.
- `imem_ready` held low for 3 cycles:
  - `imem_req` and `imem_addr` stay stable.
  - Latency is 7 cycles.
  - `ir` is unchanged until ready.
- Illegal word 0x00000013 at `pc`=8:
  - TRAP, `illegal`=1, `pc` stays 8, no further `imem_req`.
  - `rst_n` pulse clears `illegal` and returns `pc` to RESET_PC.
- `add x0,x1,x2` -> `rf_we`=0, `retire`=1, `pc` advances. Separately, `RESET_PC`=0xFFFF_FFFC -> `pc`=0 after one retire.
- Edge cases:
  - `run` dropped during EXEC -> WB completes, then IDLE with `imem_req`=0.
  - `rst_n` asserted during FETCH -> `imem_req` low immediately, `instret` unchanged from 0.
